// File: rtl/cmd_reg_arb.sv
// cmd_reg_arb: single-transaction arbiter from REQ_NUM requesters onto a shared register bus.
// Define CMD_ARB_RR_EN for round-robin arbitration; without it the lowest requester index wins.
module cmd_reg_arb #(
  parameter int REQ_NUM    = 4,
  parameter int ADDR_WIDTH = 20,
  parameter int RD_LAT     = 1
) (
  input  logic                          clks,
  input  logic                          reset_n,
  input  logic [REQ_NUM-1:0]            req_vld,
  input  logic [REQ_NUM-1:0]            req_wr,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQ_NUM*32-1:0]         req_wdata,
  output logic [REQ_NUM-1:0]            req_ack,
  output logic [31:0]                   req_rdata,
  output logic [ADDR_WIDTH-1:0]         cpu_addr,
  output logic                          cpu_wr,
  output logic                          cpu_rd,
  output logic [31:0]                   cpu_data_in,
  input  logic [31:0]                   cpu_data_out,
  output logic                          arb_busy,
  output logic [2:0]                    arb_gnt_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t                  state_q;
  logic                    wr_q;
  logic [3:0]              cnt_q;
  logic [2:0]              gnt_q;
  logic [REQ_NUM-1:0]      ack_q;
  logic [31:0]             rdata_q;
  logic [31:0]             wdata_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    cpu_wr_q;
  logic                    cpu_rd_q;
  logic                    found_d;
  logic                    wr_d;
  logic [2:0]              gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [31:0]             wdata_d;
`ifdef CMD_ARB_RR_EN
  logic [2:0]              ptr_q;
`endif

  always_comb begin
    int j;
    j       = 0;
    found_d = 1'b0;
    gnt_d   = '0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
`ifdef CMD_ARB_RR_EN
      j = (int'(ptr_q) + 1 + k) % REQ_NUM;
`else
      j = k;
`endif
      if (!found_d && req_vld[j]) begin
        found_d = 1'b1;
        gnt_d   = 3'(j);
        wr_d    = req_wr[j];
        addr_d  = req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = req_wdata[j*32 +: 32];
      end
    end
  end

  always_ff @(posedge clks or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      cpu_wr_q <= 1'b0;
      cpu_rd_q <= 1'b0;
`ifdef CMD_ARB_RR_EN
      ptr_q    <= 3'(REQ_NUM - 1);
`endif
    end else begin
      cpu_wr_q <= 1'b0;
      cpu_rd_q <= 1'b0;
      ack_q    <= '0;
      case (state_q)
        IDLE: if (found_d) begin
          state_q  <= ISSUE;
          wr_q     <= wr_d;
          gnt_q    <= gnt_d;
          addr_q   <= addr_d;
          wdata_q  <= wdata_d;
          cpu_wr_q <= wr_d;
          cpu_rd_q <= ~wr_d;
`ifdef CMD_ARB_RR_EN
          ptr_q    <= gnt_d;
`endif
        end
        ISSUE: if (wr_q || RD_LAT == 1) begin
          state_q <= ACK;
          ack_q   <= REQ_NUM'(1) << gnt_q;
          if (!wr_q) rdata_q <= cpu_data_out;
        end else begin
          state_q <= WAIT;
          cnt_q   <= 4'(RD_LAT - 1);
        end
        // read data is sampled on the edge that is RD_LAT edges after the strobe rose
        WAIT: if (cnt_q == 4'd1) begin
          state_q <= ACK;
          ack_q   <= REQ_NUM'(1) << gnt_q;
          rdata_q <= cpu_data_out;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack     = ack_q;
  assign req_rdata   = rdata_q;
  assign cpu_addr    = addr_q;
  assign cpu_wr      = cpu_wr_q;
  assign cpu_rd      = cpu_rd_q;
  assign cpu_data_in = wdata_q;
  assign arb_busy    = state_q != IDLE;
  assign arb_gnt_id  = gnt_q;
endmodule

// File: tb/tb_cmd_reg_arb.sv
// tb_cmd_reg_arb: scoreboard bench; instance a uses RD_LAT=1, instance b uses RD_LAT=3.
module tb_cmd_reg_arb;
  localparam int N  = 4;
  localparam int AW = 20;
  typedef struct {
    logic [3:0]    ack;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst_n, b_rst_n;
  logic [N-1:0]  a_vld, a_wr, a_ack, b_vld, b_wr, b_ack;
  logic [N*AW-1:0] a_addr, b_addr;
  logic [N*32-1:0] a_wdata, b_wdata;
  logic [31:0]   a_rdata, a_cdin, a_cdout, b_rdata, b_cdin, b_cdout, b_rd_val;
  logic [AW-1:0] a_caddr, b_caddr;
  logic          a_cwr, a_crd, a_busy, b_cwr, b_crd, b_busy;
  logic [2:0]    a_gid, b_gid;

  int n_tests = 0, n_fail = 0, n_xact_a = 0, a_nstrb = 0, a_nack = 0;
  int a_since = 0, b_since = 0;
  exp_t qa_s[$], qa_a[$], qb[$];

  cmd_reg_arb #(.REQ_NUM(N), .ADDR_WIDTH(AW), .RD_LAT(1)) u_a (
    .clks(clk), .reset_n(a_rst_n), .req_vld(a_vld), .req_wr(a_wr), .req_addr(a_addr),
    .req_wdata(a_wdata), .req_ack(a_ack), .req_rdata(a_rdata), .cpu_addr(a_caddr),
    .cpu_wr(a_cwr), .cpu_rd(a_crd), .cpu_data_in(a_cdin), .cpu_data_out(a_cdout),
    .arb_busy(a_busy), .arb_gnt_id(a_gid));

  cmd_reg_arb #(.REQ_NUM(N), .ADDR_WIDTH(AW), .RD_LAT(3)) u_b (
    .clks(clk), .reset_n(b_rst_n), .req_vld(b_vld), .req_wr(b_wr), .req_addr(b_addr),
    .req_wdata(b_wdata), .req_ack(b_ack), .req_rdata(b_rdata), .cpu_addr(b_caddr),
    .cpu_wr(b_cwr), .cpu_rd(b_crd), .cpu_data_in(b_cdin), .cpu_data_out(b_cdout),
    .arb_busy(b_busy), .arb_gnt_id(b_gid));

  function automatic logic [31:0] rd_fn(input logic [AW-1:0] addr);
    return 32'h5EED_0000 ^ (32'(addr) * 32'h9E37_79B1);
  endfunction

  // register-instance models: read data is driven around the capture point
  assign a_cdout = (a_crd || a_since == 1) ? rd_fn(a_caddr) : 32'h0;
  assign b_cdout = (b_since == 2 || b_since == 3) ? b_rd_val : 32'h0;

  always @(posedge clk) begin
    a_since <= a_crd ? 1 : (a_since != 0 && a_since < 15) ? a_since + 1 : a_since;
    b_since <= b_crd ? 1 : (b_since != 0 && b_since < 15) ? b_since + 1 : b_since;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack_a(output logic [3:0] got);
    got = '0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      got = a_ack;
    end
  endtask

  task automatic wait_ack_b(output logic [3:0] got);
    got = '0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      got = b_ack;
    end
  endtask

  task automatic do_a(input int id, input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata);
    exp_t e;
    logic [3:0] got;
    e.ack   = 4'(1 << id);
    e.wr    = wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = wr ? 32'h0 : rd_fn(addr);
    qa_s.push_back(e);
    qa_a.push_back(e);
    n_xact_a++;
    a_wr[id]             = wr;
    a_addr[id*AW +: AW]  = addr;
    a_wdata[id*32 +: 32] = wdata;
    a_vld[id]            = 1'b1;
    wait_ack_a(got);
    chk("t6_ack", got, e.ack);
    tick();
    a_vld = '0;
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_rst_n) begin
      if (a_cwr || a_crd) begin
        a_nstrb <= a_nstrb + 1;
        chk("a_strobe_excl", a_cwr & a_crd, 0);
        if (qa_s.size() == 0) chk("a_strobe_unexp", {a_cwr, a_crd}, 0);
        else begin
          e = qa_s.pop_front();
          chk("a_strobe_wr", a_cwr, e.wr);
          chk("a_strobe_addr", a_caddr, e.addr);
          if (e.wr) chk("a_strobe_wdata", a_cdin, e.wdata);
        end
      end
      if (a_ack != 0) begin
        a_nack <= a_nack + 1;
        if (qa_a.size() == 0) chk("a_ack_unexp", a_ack, 0);
        else begin
          e = qa_a.pop_front();
          chk("a_ack_vec", a_ack, e.ack);
          if (!e.wr) chk("a_rdata", a_rdata, e.rdata);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_rst_n && b_ack != 0) begin
      if (qb.size() == 0) chk("b_ack_unexp", b_ack, 0);
      else begin
        e = qb.pop_front();
        chk("b_ack_vec", b_ack, e.ack);
        chk("b_rdata", b_rdata, e.rdata);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ord[5];
    exp_t e;
    logic [3:0] got;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_vld = '0; a_wr = '0; a_addr = '0; a_wdata = '0;
    b_vld = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_rd_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_ctl", {a_ack, a_cwr, a_crd, a_busy, a_gid, a_caddr}, 0);
    chk("a_rst_data", {a_rdata, a_cdin}, 0);
    chk("b_rst_ctl", {b_ack, b_cwr, b_crd, b_busy, b_gid, b_caddr}, 0);
    chk("b_rst_data", {b_rdata, b_cdin}, 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();

    // all four requesters held: round-robin rotates, fixed priority keeps granting 0
`ifdef CMD_ARB_RR_EN
    ord = '{0, 1, 2, 3, 0};
`else
    ord = '{0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < N; i++) begin
      a_addr[i*AW +: AW]  = AW'(32'h100 + i);
      a_wdata[i*32 +: 32] = 32'hD000_0000 + i;
    end
    a_wr = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e.ack = 4'(1 << ord[k]); e.wr = 1'b1;
      e.addr = AW'(32'h100 + ord[k]); e.wdata = 32'hD000_0000 + ord[k]; e.rdata = '0;
      qa_s.push_back(e);
      qa_a.push_back(e);
    end
    a_vld = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack_a(got);
      chk("t3_gnt", got, 4'(1 << ord[k]));
      chk("t3_gnt_id", a_gid, ord[k]);
      tick();
      chk("t3_idle_gap", a_busy, 0);
      n_xact_a++;
    end
    a_vld = '0;
    a_wr  = '0;
    tick();

    // single write from requester 0
    e.ack = 4'b0001; e.wr = 1'b1; e.addr = 20'h00010; e.wdata = 32'hA5A5_0001; e.rdata = '0;
    qa_s.push_back(e);
    qa_a.push_back(e);
    n_xact_a++;
    a_wr[0] = 1'b1; a_addr[0 +: AW] = 20'h00010; a_wdata[0 +: 32] = 32'hA5A5_0001; a_vld[0] = 1'b1;
    tick();
    chk("t1_cwr", a_cwr, 1);
    chk("t1_crd", a_crd, 0);
    chk("t1_addr", a_caddr, 20'h00010);
    chk("t1_wdata", a_cdin, 32'hA5A5_0001);
    tick();
    chk("t1_ack", a_ack, 4'b0001);
    chk("t1_strobes_low", {a_cwr, a_crd}, 0);
    tick();
    a_vld = '0;
    chk("t1_idle", a_busy, 0);

    for (int n = 0; n < 100; n++)
      do_a(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom), $urandom);

    // RD_LAT=3 read from requester 2
    b_addr[2*AW +: AW] = 20'h00200; b_rd_val = 32'h1234_5678;
    e.ack = 4'b0100; e.wr = 1'b0; e.addr = 20'h00200; e.wdata = '0; e.rdata = 32'h1234_5678;
    qb.push_back(e);
    b_vld[2] = 1'b1;
    tick();
    chk("t2_crd", b_crd, 1);
    chk("t2_addr", b_caddr, 20'h00200);
    tick();
    chk("t2_rd_pulse", b_crd, 0);
    chk("t2_noack1", b_ack, 0);
    tick();
    chk("t2_noack2", b_ack, 0);
    tick();
    chk("t2_ack", b_ack, 4'b0100);
    chk("t2_rdata", b_rdata, 32'h1234_5678);
    chk("t2_gid", b_gid, 2);
    tick();
    b_vld = '0;
    chk("t2_idle", b_busy, 0);

    // requester 1 withdraws during the wait; ack still arrives on schedule
    b_addr[1*AW +: AW] = 20'h00404; b_rd_val = 32'hCAFE_0004;
    e.ack = 4'b0010; e.addr = 20'h00404; e.rdata = 32'hCAFE_0004;
    qb.push_back(e);
    b_vld[1] = 1'b1;
    tick();
    tick();
    b_vld[1] = 1'b0;
    tick();
    chk("t4_noack_early", b_ack, 0);
    tick();
    chk("t4_ack", b_ack, 4'b0010);
    chk("t4_rdata", b_rdata, 32'hCAFE_0004);
    tick();
    chk("t4_no_more", b_ack, 0);

    // reset in the middle of a read wait
    b_addr[0 +: AW] = 20'h00008; b_rd_val = 32'hDEAD_0008;
    b_vld[0] = 1'b1;
    tick();
    chk("t5_crd", b_crd, 1);
    tick();
    #3;
    b_rst_n = 1'b0;
    #1;
    chk("t5_async_ctl", {b_ack, b_cwr, b_crd, b_busy, b_gid, b_caddr}, 0);
    chk("t5_async_rdata", b_rdata, 0);
    b_vld = '0;
    tick();
    tick();
    b_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_ack", b_ack, 0);
    end
    b_addr[2*AW +: AW] = 20'h00220; b_rd_val = 32'h0000_F00D;
    e.ack = 4'b0001; e.addr = 20'h00008; e.rdata = 32'h0000_F00D;
    qb.push_back(e);
    e.ack = 4'b0100; e.addr = 20'h00220; e.rdata = 32'h0000_BEEF;
    qb.push_back(e);
    b_vld = 4'b0101;
    wait_ack_b(got);
    chk("t5_first", got, 4'b0001);
    tick();
    b_vld[0] = 1'b0;
    b_rd_val = 32'h0000_BEEF;
    wait_ack_b(got);
    chk("t5_second", got, 4'b0100);
    tick();
    b_vld = '0;
    repeat (3) tick();

    chk("a_strobe_count", a_nstrb, n_xact_a);
    chk("a_ack_count", a_nack, n_xact_a);
    chk("qa_drain", qa_a.size() + qa_s.size(), 0);
    chk("qb_drain", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
